// File: rtl/aq_spsram_pkg.sv
// aq_spsram_pkg: shared types and helpers for the generic single-port SRAM wrapper.
// Optional feature macro: AQ_SPSRAM_PARITY_EN (one even-parity bit per stored word).
package aq_spsram_pkg;

  // Controller state: sweeping zeros through the array, or serving user accesses.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } aqSpsramState_e;

  // Default geometry; the address width default is the clear-pointer width of the default depth.
  localparam int AQ_SPSRAM_DEF_DEPTH = 64;
  localparam int AQ_SPSRAM_DEF_PTR_W = $clog2(AQ_SPSRAM_DEF_DEPTH);

  // Widest data word the parity helper accepts; callers zero-extend narrower words.
  localparam int AQ_SPSRAM_MAX_W = 256;

  // Clear-pointer width for a given depth (never narrower than one bit).
  function automatic int aqPtrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic aqParity(input logic [AQ_SPSRAM_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/aq_spsram_array.sv
// aq_spsram_array: behavioural storage with one bit-masked write port and a registered read.
// No reset and no control logic, so it can later be replaced by a foundry macro.
// Optional feature macro: AQ_SPSRAM_PARITY_EN (stores a parity bit beside each word).
module aq_spsram_array
  import aq_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 58,
  parameter int DEPTH      = 64
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wmask_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o
`ifdef AQ_SPSRAM_PARITY_EN
  ,
  output logic                  rpar_o
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] merged;

  // Unmasked bits keep their stored value; masked bits take the new data.
  assign merged  = (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
  assign rdata_o = rdata_q;

  // Single port: write the merged word, and capture read data only when a read is issued.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= merged;
    end
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

`ifdef AQ_SPSRAM_PARITY_EN
  logic par [DEPTH];
  logic rpar_q;

  assign rpar_o = rpar_q;

  // Parity covers the final merged word so partial writes keep it consistent.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      par[addr_i] <= aqParity(AQ_SPSRAM_MAX_W'(merged));
    end
    if (re_i) begin
      rpar_q <= par[addr_i];
    end
  end
`endif

endmodule

// File: rtl/aq_spsram_gen.sv
// aq_spsram_gen: generic single-port SRAM wrapper with a hardware clear engine
// and an optional output pipeline stage (OUT_REG). READY gates user accesses.
// Optional feature macro: AQ_SPSRAM_PARITY_EN (adds the PERR output).
module aq_spsram_gen
  import aq_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = AQ_SPSRAM_DEF_PTR_W,
  parameter int DATA_WIDTH = 58,
  parameter int DEPTH      = AQ_SPSRAM_DEF_DEPTH,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVLD,
  input  logic                  CLR_REQ,
  output logic                  READY,
  output logic                  CLR_DONE
`ifdef AQ_SPSRAM_PARITY_EN
  ,
  output logic                  PERR
`endif
);

  localparam int                PTR_W     = aqPtrWidth(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  aqSpsramState_e        state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  clrDone_q, clrDone_d;
  logic                  inRange, userAcc, userWr, userRd, clearing;
  logic                  arrWe, arrRe;
  logic [ADDR_WIDTH-1:0] arrAddr;
  logic [DATA_WIDTH-1:0] arrMask, arrData, arrRdata;
  logic                  rdVld1_q, zero1_q;
  logic [DATA_WIDTH-1:0] q1;

  assign READY    = (state_q == ST_IDLE);
  assign CLR_DONE = clrDone_q;

  // Addresses at or beyond DEPTH are not backed by storage.
  assign inRange  = ({1'b0, A} < DEPTH_EXT);
  assign userAcc  = READY && !CEN && !RST;
  assign userWr   = userAcc && GWEN && inRange;
  assign userRd   = userAcc && !GWEN;
  assign clearing = (state_q == ST_CLEAR) && !RST;

  // The clear engine owns the port for its whole pass; users are locked out by READY.
  assign arrWe   = clearing || userWr;
  assign arrRe   = userRd && inRange;
  assign arrAddr = clearing ? ADDR_WIDTH'(ptr_q) : A;
  assign arrMask = clearing ? '1 : WEN;
  assign arrData = clearing ? '0 : D;

  // Next-state logic: one word cleared per cycle, then serve accesses until a clear request.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clrDone_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d   = ST_IDLE;
          ptr_d     = '0;
          clrDone_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Controller registers; reset always restarts a full clear pass from word 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      clrDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clrDone_q <= clrDone_d;
    end
  end

  // First read stage: the array holds its own data, so a flag forces zero after reset or an out-of-range read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdVld1_q <= 1'b0;
      zero1_q  <= 1'b1;
    end else begin
      rdVld1_q <= userRd;
      if (userRd) begin
        zero1_q <= !inRange;
      end
    end
  end

  assign q1 = zero1_q ? '0 : arrRdata;

`ifdef AQ_SPSRAM_PARITY_EN
  logic arrRpar;
  logic perr1;

  assign perr1 = rdVld1_q && !zero1_q && (aqParity(AQ_SPSRAM_MAX_W'(arrRdata)) != arrRpar);
`endif

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic [DATA_WIDTH-1:0] q2_q;
      logic                  vld2_q;
`ifdef AQ_SPSRAM_PARITY_EN
      logic                  perr2_q;
`endif

      // Optional output stage: Q holds until the next delivered read.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q2_q   <= '0;
          vld2_q <= 1'b0;
        end else begin
          vld2_q <= rdVld1_q;
          if (rdVld1_q) begin
            q2_q <= q1;
          end
        end
      end

      assign Q    = q2_q;
      assign QVLD = vld2_q;

`ifdef AQ_SPSRAM_PARITY_EN
      // Parity error travels alongside its data through the output stage.
      always_ff @(posedge CLK) begin
        if (RST) begin
          perr2_q <= 1'b0;
        end else begin
          perr2_q <= perr1;
        end
      end

      assign PERR = perr2_q;
`endif
    end else begin : gNoOutReg
      assign Q    = q1;
      assign QVLD = rdVld1_q;
`ifdef AQ_SPSRAM_PARITY_EN
      assign PERR = perr1;
`endif
    end
  endgenerate

  aq_spsram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) uArray (
    .clk_i  (CLK),
    .addr_i (arrAddr),
    .we_i   (arrWe),
    .wmask_i(arrMask),
    .wdata_i(arrData),
    .re_i   (arrRe),
    .rdata_o(arrRdata)
`ifdef AQ_SPSRAM_PARITY_EN
    ,
    .rpar_o (arrRpar)
`endif
  );

endmodule

// File: tb/tb_aq_spsram_gen.sv
// tb_aq_spsram_gen: directed bench for aq_spsram_gen.
// Instance A: DEPTH=64, OUT_REG=0. Instance B: DEPTH=48, OUT_REG=1. Both share one input bus.
// Parity checks are compiled in when AQ_SPSRAM_PARITY_EN is defined.
module tb_aq_spsram_gen;

  localparam int AW = 6;
  localparam int DW = 58;
  localparam logic [DW-1:0] ONES   = '1;
  localparam logic [DW-1:0] MERGED = 58'h3FF_FFFF_FFFF_FFF0;
  localparam logic [DW-1:0] D7     = 58'h155_5555_0000_ABCD;

  logic          clk;
  logic          rst;
  logic          cen;
  logic          gwen;
  logic          clrReq;
  logic [AW-1:0] addr;
  logic [DW-1:0] wen;
  logic [DW-1:0] din;
  logic [DW-1:0] qA, qB;
  logic          vldA, vldB, readyA, readyB, doneA, doneB;
`ifdef AQ_SPSRAM_PARITY_EN
  logic          perrA, perrB;
`endif

  int checks = 0;
  int errors = 0;

  int lowA, lowB, doneCntA, doneCntB, vldCntA, vldCntB;
  logic doneRiseA;
  logic [DW-1:0] qBAtVld;

  aq_spsram_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .OUT_REG(0)) uDutA (
    .CLK(clk), .RST(rst), .A(addr), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(din),
    .Q(qA), .QVLD(vldA), .CLR_REQ(clrReq), .READY(readyA), .CLR_DONE(doneA)
`ifdef AQ_SPSRAM_PARITY_EN
    , .PERR(perrA)
`endif
  );

  aq_spsram_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(48), .OUT_REG(1)) uDutB (
    .CLK(clk), .RST(rst), .A(addr), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(din),
    .Q(qB), .QVLD(vldB), .CLR_REQ(clrReq), .READY(readyB), .CLR_DONE(doneB)
`ifdef AQ_SPSRAM_PARITY_EN
    , .PERR(perrB)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    cen    = 1'b1;
    gwen   = 1'b0;
    clrReq = 1'b0;
    addr   = '0;
    wen    = '0;
    din    = '0;
  endtask

  task automatic applyStimulus(input logic c, input logic g, input logic [AW-1:0] a,
                               input logic [DW-1:0] w, input logic [DW-1:0] d, input logic r);
    cen    = c;
    gwen   = g;
    addr   = a;
    wen    = w;
    din    = d;
    clrReq = r;
    tick();
    setIdle();
  endtask

  task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] w);
    applyStimulus(1'b0, 1'b1, a, w, d, 1'b0);
  endtask

  task automatic readWord(input logic [AW-1:0] a);
    applyStimulus(1'b0, 1'b0, a, '0, '0, 1'b0);
  endtask

  // Runs 100 cycles from the current sample, counting READY-low cycles and pulses;
  // with traffic, drives writes and a repeated clear request while both arrays clear.
  task automatic runClearPass(input bit traffic);
    bit seenA;
    lowA = 0; lowB = 0; doneCntA = 0; doneCntB = 0; vldCntB = 0;
    doneRiseA = 1'b0; qBAtVld = '0; seenA = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!readyA) lowA++;
      if (!readyB) lowB++;
      if (doneA) doneCntA++;
      if (doneB) doneCntB++;
      if (readyA && !seenA) begin
        seenA     = 1'b1;
        doneRiseA = doneA;
      end
      if (vldB) begin
        vldCntB++;
        qBAtVld = qB;
      end
      if (traffic && k >= 2 && k < 40) begin
        cen  = 1'b0;
        gwen = 1'b1;
        addr = AW'(k);
        wen  = ONES;
        din  = ONES;
      end else begin
        cen  = 1'b1;
        gwen = 1'b0;
      end
      clrReq = traffic && (k == 30);
      tick();
    end
    setIdle();
  endtask

  initial begin
    setIdle();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    checkOutput("rst_readyA", 64'(readyA), 64'(1'b0));
    checkOutput("rst_qA",     64'(qA),     64'h0);
    checkOutput("rst_vldA",   64'(vldA),   64'(1'b0));
    checkOutput("rst_doneA",  64'(doneA),  64'(1'b0));
    checkOutput("rst_qB",     64'(qB),     64'h0);
    checkOutput("rst_vldB",   64'(vldB),   64'(1'b0));

    // Power-on clear pass
    rst = 1'b0;
    runClearPass(1'b0);
    checkOutput("init_lowA",     64'(lowA),      64'd64);
    checkOutput("init_lowB",     64'(lowB),      64'd48);
    checkOutput("init_doneCntA", 64'(doneCntA),  64'd1);
    checkOutput("init_doneCntB", 64'(doneCntB),  64'd1);
    checkOutput("init_doneRise", 64'(doneRiseA), 64'(1'b1));

    // Read of a cleared word, latency 1 on A and 2 on B
    readWord(6'd5);
    checkOutput("rd5_qA",   64'(qA),   64'h0);
    checkOutput("rd5_vldA", 64'(vldA), 64'(1'b1));
    checkOutput("rd5_vldB", 64'(vldB), 64'(1'b0));
    tick();
    checkOutput("rd5_vldA_off", 64'(vldA), 64'(1'b0));
    checkOutput("rd5_vldB",     64'(vldB), 64'(1'b1));
    checkOutput("rd5_qB",       64'(qB),   64'h0);

    // Bit-masked write merge
    writeWord(6'd3, ONES, ONES);
    checkOutput("wr_vldA", 64'(vldA), 64'(1'b0));
    writeWord(6'd3, '0, 58'hF);
    readWord(6'd3);
    checkOutput("merge_qA",   64'(qA),   64'(MERGED));
    checkOutput("merge_vldA", 64'(vldA), 64'(1'b1));
    tick();
    checkOutput("merge_qB",   64'(qB),   64'(MERGED));
    checkOutput("merge_vldB", 64'(vldB), 64'(1'b1));

    // Q holds across idle cycles; QVLD is a single pulse
    writeWord(6'd7, D7, ONES);
    readWord(6'd7);
    checkOutput("hold_qA_first", 64'(qA), 64'(D7));
    vldCntA = 0;
    vldCntB = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vldA) vldCntA++;
      if (vldB) vldCntB++;
    end
    checkOutput("hold_vldCntA", 64'(vldCntA), 64'd0);
    checkOutput("hold_vldCntB", 64'(vldCntB), 64'd1);
    checkOutput("hold_qA",      64'(qA),      64'(D7));
    checkOutput("hold_qB",      64'(qB),      64'(D7));

    // Clear request together with a read; accesses and a second request during the pass
    writeWord(6'd3, 58'h123, ONES);
    applyStimulus(1'b0, 1'b0, 6'd3, '0, '0, 1'b1);
    checkOutput("clrrd_qA",     64'(qA),     64'h123);
    checkOutput("clrrd_vldA",   64'(vldA),   64'(1'b1));
    checkOutput("clrrd_readyA", 64'(readyA), 64'(1'b0));
    runClearPass(1'b1);
    checkOutput("clr_lowA",     64'(lowA),     64'd64);
    checkOutput("clr_lowB",     64'(lowB),     64'd48);
    checkOutput("clr_doneCntA", 64'(doneCntA), 64'd1);
    checkOutput("clr_vldCntB",  64'(vldCntB),  64'd1);
    checkOutput("clr_qBAtVld",  64'(qBAtVld),  64'h123);
    readWord(6'd3);
    checkOutput("post_rd3_qA",  64'(qA), 64'h0);
    readWord(6'd10);
    checkOutput("post_rd10_qA", 64'(qA), 64'h0);
    readWord(6'd20);
    checkOutput("post_rd20_qA", 64'(qA), 64'h0);

    // Out-of-range on B (DEPTH=48): write dropped, read returns zero with QVLD
    writeWord(6'd63, 58'hABC, ONES);
    writeWord(6'd4, 58'h77, ONES);
    readWord(6'd4);
    checkOutput("oor_rd4_qA", 64'(qA), 64'h77);
    readWord(6'd63);
    checkOutput("oor_rd63_qA", 64'(qA),   64'hABC);
    checkOutput("oor_rd4_qB",  64'(qB),   64'h77);
    checkOutput("oor_rd4_vldB", 64'(vldB), 64'(1'b1));
    tick();
    checkOutput("oor_rd63_qB",   64'(qB),   64'h0);
    checkOutput("oor_rd63_vldB", 64'(vldB), 64'(1'b1));

    // Reset in the middle of a clear pass
    applyStimulus(1'b0, 1'b0, 6'd4, '0, '0, 1'b1);
    checkOutput("mid_qA", 64'(qA), 64'h77);
    tick();
    checkOutput("mid_qB", 64'(qB), 64'h77);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("midrst_qA",     64'(qA),     64'h0);
    checkOutput("midrst_qB",     64'(qB),     64'h0);
    checkOutput("midrst_readyA", 64'(readyA), 64'(1'b0));
    checkOutput("midrst_doneA",  64'(doneA),  64'(1'b0));
    rst = 1'b0;
    runClearPass(1'b0);
    checkOutput("midrst_lowA", 64'(lowA), 64'd64);
    checkOutput("midrst_lowB", 64'(lowB), 64'd48);
    readWord(6'd63);
    checkOutput("midrst_rd63_qA", 64'(qA), 64'h0);

`ifdef AQ_SPSRAM_PARITY_EN
    // Parity: a backdoor bit flip is flagged, an untouched word is not
    writeWord(6'd9, 58'h1, ONES);
    writeWord(6'd8, 58'h3, ONES);
    uDutA.uArray.mem[9][0] = ~uDutA.uArray.mem[9][0];
    readWord(6'd9);
    checkOutput("par_rd9_vldA",  64'(vldA),  64'(1'b1));
    checkOutput("par_rd9_perrA", 64'(perrA), 64'(1'b1));
    checkOutput("par_rd9_qA",    64'(qA),    64'h0);
    readWord(6'd8);
    checkOutput("par_rd8_perrA", 64'(perrA), 64'(1'b0));
    checkOutput("par_rd8_qA",    64'(qA),    64'h3);
    checkOutput("par_rd9_perrB", 64'(perrB), 64'(1'b0));
    checkOutput("par_rd9_qB",    64'(qB),    64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_spsram_gen.md
Name: aq_spsram_gen

Overview:
Parametrised, generic single-port SRAM wrapper for the aq_* cache/TLB arrays; successor to the fixed-geometry per-macro wrappers. It provides a behavioural storage array with the same CEN/GWEN/WEN/Q access semantics as the existing wrappers. On top of that it adds:
- a hardware clear engine that zeroes every word after reset or on request;
- an optional output pipeline register.
Upstream control (icache/dcache/jtlb tag and data arrays) waits on READY before issuing accesses.

Parameters:
ADDR_WIDTH, 6, address bits.
DATA_WIDTH, 58, word width in bits.
DEPTH, 64, words; 2 <= DEPTH <= 2**ADDR_WIDTH.
OUT_REG, 0, 1 adds one output flop stage (read latency 2 instead of 1).

Ports:
CLK  input  1  clock; all state on rising edge.
RST  input  1  synchronous, active-high reset.
A  input  ADDR_WIDTH  access address.
CEN  input  1  chip enable, active low.
GWEN  input  1  global write enable, active high (1 = write, 0 = read).
WEN  input  DATA_WIDTH  per-bit write enable, active high.
D  input  DATA_WIDTH  write data.
Q  output  DATA_WIDTH  read data.
QVLD  output  1  one-cycle pulse marking new read data on Q.
CLR_REQ  input  1  pulse that starts a full-array clear.
READY  output  1  1 = array accepts user accesses.
CLR_DONE  output  1  one-cycle pulse when a clear finishes.

Behaviour:
- Reset values: Q=0, QVLD=0, READY=0, CLR_DONE=0, FSM=CLEAR, clear pointer=0.
- FSM states:
  - CLEAR: writes all-zero to address ptr each cycle; ptr increments. At ptr==DEPTH-1 the write completes, the FSM moves to IDLE, and CLR_DONE pulses for that single cycle.
  - IDLE: READY=1; user accesses serviced.
  - IDLE -> CLEAR on CLR_REQ=1. ptr resets to 0 and READY drops the next cycle.
  - Array contents are unaffected by RST itself; only the clear pass zeroes them.
- Clear duration is exactly DEPTH cycles. READY is 0 for the whole pass.
- User access (only when READY=1 and CEN=0):
  - GWEN=1: mem[A][i] <= D[i] for each i where WEN[i]=1; other bits are unchanged. Q holds its previous value and QVLD=0.
  - GWEN=0: read. With OUT_REG=0, Q=mem[A] and QVLD=1 one cycle after the access edge. With OUT_REG=1, both appear two cycles after.
- Q holds its last read value indefinitely when there is no read (macro-like). There is no write-through.
- Accesses presented while READY=0 are ignored: no write, no QVLD.
- CLR_REQ in the same cycle as a user access in IDLE: the access is performed first. The clear starts the next cycle, and a read's QVLD still fires.
- CLR_REQ while already in CLEAR is ignored; the pass is not restarted.
- An OUT_REG stage in flight when a clear starts still delivers its data and QVLD.
- A ≥ DEPTH with CEN=0:
  - Write is dropped.
  - Read returns all-zero with QVLD=1.
- RST mid-clear: FSM restarts CLEAR from ptr 0 the cycle after RST deasserts. Pipeline Q and QVLD are zeroed.

Optional Feature:
AQ_SPSRAM_PARITY_EN:
- Defined:
  - Each word stores one extra even-parity bit, computed over the final merged word after the WEN mask is applied.
  - The clear pass writes parity 0.
  - Adds output PERR (1 bit), asserted together with QVLD when the stored parity mismatches the read data. PERR resets to 0.
- Undefined: no extra storage bit and no PERR port.

Decomposition:
- Package aq_spsram_pkg:
  - FSM state enum (CLEAR, IDLE);
  - localparam for clear-pointer width, $clog2(DEPTH);
  - parity function.
- Sub-module aq_spsram_array: pure storage with single write port and registered read, bit-masked write. No FSM, no reset. Instantiated once; wraps the array so it can be swapped for a foundry macro later.

Test Plan:
- Reset with DEPTH=64, OUT_REG=0 -> READY=0 for exactly 64 cycles then 1; CLR_DONE pulses once; a read of A=5 returns Q=0 with QVLD=1 on the next cycle.
- Write A=3, D=58'h3FF_FFFF_FFFF_FFFF, WEN all 1; then write A=3, D=0, WEN=58'h00F -> read A=3 gives 58'h3FF_FFFF_FFFF_FFF0 after 1 cycle (OUT_REG=0) and after 2 cycles (OUT_REG=1).
- Read A=7 then idle 10 cycles with CEN=1 -> Q holds the A=7 data; QVLD high for only 1 cycle.
- CLR_REQ simultaneous with a read of A=3 holding 58'h123 -> QVLD=1 with Q=58'h123; READY=0 for 64 cycles; a later read of A=3 returns 0.
- Accesses with CEN=0, GWEN=1 during the clear pass -> no effect; after CLR_DONE every address reads 0. Read A=63 with DEPTH=48 -> Q=0, QVLD=1.
- With AQ_SPSRAM_PARITY_EN defined: write A=9 D=58'h1, force one array bit flip via the bench backdoor -> read A=9 gives PERR=1 together with QVLD. An unmodified word gives PERR=0.
